// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, start/data/stop FSM, and a one-entry
// valid/ready output register with frame-error and overrun pulses.
module uart_receiver #(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int DATA_BITS      = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 uart_rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_error_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 rx_s;

  // Both flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  assign rx_s    = sync_q[1];
  assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (idx_q == IDX_LAST) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              // A load on the accepting edge keeps valid high with the new byte.
              if (!valid_q || ready_i) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign frame_error_o = ferr_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver (N=8): directed frames plus a random byte
// stream, checked against a frame-level model of the receiver.
module tb_uart_receiver;
  localparam int N  = 8;
  localparam int H  = N / 2;
  localparam int DB = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic          rdy   = 1'b0;
  logic [DB-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  uart_receiver #(
    .CLOCKS_PER_BIT(N),
    .DATA_BITS     (DB)
  ) dut (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .uart_rx_i    (rx),
    .ready_i      (rdy),
    .data_o       (data),
    .valid_o      (valid),
    .frame_error_o(ferr),
    .overrun_o    (ovr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int exp_ferr  = 0;
  int exp_ovr   = 0;
  int ferr_seen = 0;
  int ovr_seen  = 0;
  bit model_full = 1'b0;
  logic [7:0] exp_q[$];
  int         acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Frame-level model: a good frame either lands in the output slot or, if the
  // slot is still full and the consumer is not taking it, is dropped as an overrun.
  function automatic void expect_good(input logic [7:0] b);
    if (model_full && !rdy) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(b);
      model_full = !rdy;
    end
  endfunction

  // Monitor: pops the scoreboard on every accepted byte and checks output rules.
  logic       pv = 1'b0, pr = 1'b0, pf = 1'b0, po = 1'b0;
  logic [7:0] pd = '0;
  always @(negedge clk) begin
    if (valid && rdy) begin
      acc_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got=%0h want=none", data);
      end else begin
        logic [7:0] w;
        w = exp_q.pop_front();
        if (data !== w) begin
          errors++;
          $display("FAIL rx_data got=%0h want=%0h", data, w);
        end
      end
    end
    if (pv && !pr && valid) chk("data_hold", {24'd0, data}, {24'd0, pd});
    if (ferr) begin
      ferr_seen++;
      chk("ferr_width", {31'd0, pf}, 32'd0);
    end
    if (ovr) begin
      ovr_seen++;
      chk("ovr_width", {31'd0, po}, 32'd0);
    end
    pv = valid; pr = rdy; pd = data; pf = ferr; po = ovr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(N);
    end
  endtask

  task automatic pulse_ready();
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    model_full = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, rise, fall;
    logic [7:0] b;
    bit bad;

    // Reset state
    tick(3);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic receive with latency measurement
    rdy = 1'b0;
    expect_good(8'hA5);
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clk); #1;
          if (valid) begin lat = i - 1; break; end
        end
      end
    join
    chk("latency", lat, 32'd78);
    tick(20);
    chk("hold_valid", {31'd0, valid}, 32'd1);
    chk("hold_data", {24'd0, data}, 32'hA5);
    pulse_ready();
    chk("valid_clear", {31'd0, valid}, 32'd0);
    tick(4);

    // Glitch on the line
    begin
      int f0;
      f0 = ferr_seen;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      rise = -1; fall = -1;
      for (int i = 0; i < 30; i++) begin
        tick(1);
        if (busy && rise < 0) rise = i;
        if (!busy && rise >= 0 && fall < 0) fall = i;
      end
      chk("glitch_busy_rose", {31'd0, rise >= 0}, 32'd1);
      chk("glitch_busy_len", {31'd0, (fall >= 0) && (fall - rise <= H + 3)}, 32'd1);
      chk("glitch_no_valid", {31'd0, valid}, 32'd0);
      chk("glitch_no_ferr", ferr_seen, f0);
    end

    // Framing error followed by a good frame
    exp_ferr++;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(3 * N);
    chk("ferr_busy_held", {31'd0, busy}, 32'd1);
    chk("ferr_no_valid", {31'd0, valid}, 32'd0);
    rx = 1'b1;
    tick(2 * N);
    chk("ferr_busy_done", {31'd0, busy}, 32'd0);
    chk("ferr_count", ferr_seen, exp_ferr);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1);
    tick(4);
    chk("after_ferr_data", {24'd0, data}, 32'h81);
    chk("after_ferr_valid", {31'd0, valid}, 32'd1);
    pulse_ready();
    tick(4);

    // Overrun
    expect_good(8'h11);
    expect_good(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    chk("ovr_data", {24'd0, data}, 32'h11);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_count", ovr_seen, exp_ovr);
    pulse_ready();
    tick(4);

    // Reset mid-frame during data bit 3
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (N + 3 * N + H) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_data", {24'd0, data}, 32'd0);
        chk("mid_rst_ferr", {31'd0, ferr}, 32'd0);
        chk("mid_rst_ovr", {31'd0, ovr}, 32'd0);
      end
    join
    model_full = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rdy = 1'b1;
    expect_good(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(4);
    chk("post_rst_ferr", ferr_seen, exp_ferr);
    chk("post_rst_ovr", ovr_seen, exp_ovr);
    chk("post_rst_drained", exp_q.size(), 32'd0);

    // Streaming back to back with ready held high
    acc_cyc.delete();
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    chk("stream_count", acc_cyc.size(), 32'd2);
    if (acc_cyc.size() == 2) chk("stream_spacing", acc_cyc[1] - acc_cyc[0], 32'd80);
    chk("stream_ovr", ovr_seen, exp_ovr);

    // Random stream with occasional framing errors
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        exp_ferr++;
        send_frame(b, 1'b0);
        rx = 1'b0;
        tick($urandom_range(0, 2) * N);
        rx = 1'b1;
        tick(N + $urandom_range(0, N));
      end else begin
        expect_good(b);
        send_frame(b, 1'b1);
        tick($urandom_range(0, 2 * N));
      end
    end
    tick(10);
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_ferr", ferr_seen, exp_ferr);
    chk("rand_ovr", ovr_seen, exp_ovr);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
